// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer
//   On-chip RGB frame store. Captures one frame of (row, col, rgb) pixels
//   from the processing write stream, flags completion, then serves
//   random-access reads by row/column with one cycle of latency.
//
// Ports
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   WR_VALID              write-side pixel strobe
//   WR_WIDTH, WR_HEIGHT   frame size, latched on the first write of a frame
//   WR_ROW, WR_COL        pixel position (0-based)
//   WR_RED/GREEN/BLUE     pixel components
//   CLEAR                 discard the stored frame, return to idle
//   RD_ROW, RD_COL        read position, sampled every cycle while ready
//   RD_RED/GREEN/BLUE     read pixel, one cycle after the address
//   RD_VALID              RD_* carries a pixel read while ready
//   WIDTH, HEIGHT         latched frame size
//   FRAME_READY           frame complete, reads are being served
//   ERR                   sticky bounds error
//
// Configuration
//   FB_BOUNDS_CHECK_EN    when defined, out-of-range writes are dropped,
//                         out-of-range reads return zero, and both set ERR.
//                         When undefined, addresses wrap and ERR is tied 0.

module pixel_frame_buffer #(
  parameter int MAX_PIXELS = 393216,
  parameter int ADDR_W     = 19
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_VALID,
  input  logic [11:0] WR_WIDTH,
  input  logic [11:0] WR_HEIGHT,
  input  logic [11:0] WR_ROW,
  input  logic [11:0] WR_COL,
  input  logic [7:0]  WR_RED,
  input  logic [7:0]  WR_GREEN,
  input  logic [7:0]  WR_BLUE,
  input  logic        CLEAR,
  input  logic [11:0] RD_ROW,
  input  logic [11:0] RD_COL,
  output logic [7:0]  RD_RED,
  output logic [7:0]  RD_GREEN,
  output logic [7:0]  RD_BLUE,
  output logic        RD_VALID,
  output logic [11:0] WIDTH,
  output logic [11:0] HEIGHT,
  output logic        FRAME_READY,
  output logic        ERR
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  logic [1:0]        state;
  logic [23:0]       count;
  logic [23:0]       total;
  logic [23:0]       mem [MAX_PIXELS];

  logic [11:0]       eff_w;
  logic [23:0]       new_total;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_live;
  logic              wr_ok;
  logic              wr_take;
  logic              rd_live;
  logic              rd_ok;

  // The first write of a frame is placed using the incoming width, since
  // WIDTH is only latched on that same edge.
  always_comb begin
    eff_w     = (state == ST_IDLE) ? WR_WIDTH : WIDTH;
    new_total = 24'(WR_WIDTH) * 24'(WR_HEIGHT);
    wr_addr   = ADDR_W'(24'(WR_ROW) * 24'(eff_w) + 24'(WR_COL));
    rd_addr   = ADDR_W'(24'(RD_ROW) * 24'(WIDTH) + 24'(RD_COL));
    // A zero-sized frame never starts; CLEAR always wins over a write.
    wr_live   = WR_VALID && !CLEAR &&
                ((state == ST_IDLE && WR_WIDTH != '0 && WR_HEIGHT != '0) ||
                 state == ST_CAPTURE);
    rd_live   = (state == ST_READY) && !CLEAR;
  end

`ifdef FB_BOUNDS_CHECK_EN
  logic [11:0] eff_h;
  logic [23:0] wr_full;
  logic [23:0] rd_full;
  logic        err_q;

  always_comb begin
    eff_h   = (state == ST_IDLE) ? WR_HEIGHT : HEIGHT;
    wr_full = 24'(WR_ROW) * 24'(eff_w) + 24'(WR_COL);
    rd_full = 24'(RD_ROW) * 24'(WIDTH) + 24'(RD_COL);
    wr_ok   = (WR_ROW < eff_h) && (WR_COL < eff_w) && (wr_full < 24'(MAX_PIXELS));
    rd_ok   = (RD_ROW < HEIGHT) && (RD_COL < WIDTH) && (rd_full < 24'(MAX_PIXELS));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      err_q <= 1'b0;
    else if (CLEAR)
      err_q <= 1'b0;
    else if ((wr_live && !wr_ok) || (rd_live && !rd_ok))
      err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
  assign ERR   = 1'b0;
`endif

  assign wr_take     = wr_live && wr_ok;
  assign FRAME_READY = (state == ST_READY);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= ST_IDLE;
      count  <= '0;
      total  <= '0;
      WIDTH  <= '0;
      HEIGHT <= '0;
    end else if (CLEAR) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_take) begin
            WIDTH  <= WR_WIDTH;
            HEIGHT <= WR_HEIGHT;
            total  <= new_total;
            count  <= 24'd1;
            // A 1x1 frame is complete after its only write.
            state  <= (new_total == 24'd1) ? ST_READY : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (wr_take) begin
            count <= count + 24'd1;
            if (count + 24'd1 == total)
              state <= ST_READY;
          end
        end
        ST_READY: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel RAM has no reset; its contents are undefined after reset.
  always_ff @(posedge CLK) begin
    if (wr_take)
      mem[wr_addr] <= {WR_RED, WR_GREEN, WR_BLUE};
  end

  // Read data holds its last value whenever no read is being served.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RD_RED   <= '0;
      RD_GREEN <= '0;
      RD_BLUE  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= rd_live;
      if (rd_live)
        {RD_RED, RD_GREEN, RD_BLUE} <= rd_ok ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb_pixel_frame_buffer
//   Directed bench for pixel_frame_buffer: frame capture, gapped writes,
//   CLEAR racing a write, asynchronous reset mid-frame, 1x1 and zero-size
//   frames, and the FB_BOUNDS_CHECK_EN / wrap behaviour of the build.

module tb_pixel_frame_buffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WR_VALID;
  logic [11:0] WR_WIDTH, WR_HEIGHT, WR_ROW, WR_COL;
  logic [7:0]  WR_RED, WR_GREEN, WR_BLUE;
  logic        CLEAR;
  logic [11:0] RD_ROW, RD_COL;
  logic [7:0]  RD_RED, RD_GREEN, RD_BLUE;
  logic        RD_VALID;
  logic [11:0] WIDTH, HEIGHT;
  logic        FRAME_READY;
  logic        ERR;

  int total_n = 0;
  int bad_n   = 0;

  always #5 CLK = ~CLK;

  pixel_frame_buffer #(.MAX_PIXELS(393216), .ADDR_W(19)) dut (
    .CLK(CLK), .RESET(RESET), .WR_VALID(WR_VALID),
    .WR_WIDTH(WR_WIDTH), .WR_HEIGHT(WR_HEIGHT), .WR_ROW(WR_ROW), .WR_COL(WR_COL),
    .WR_RED(WR_RED), .WR_GREEN(WR_GREEN), .WR_BLUE(WR_BLUE), .CLEAR(CLEAR),
    .RD_ROW(RD_ROW), .RD_COL(RD_COL),
    .RD_RED(RD_RED), .RD_GREEN(RD_GREEN), .RD_BLUE(RD_BLUE), .RD_VALID(RD_VALID),
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAME_READY(FRAME_READY), .ERR(ERR)
  );

  typedef struct {
    int          frame;
    logic [11:0] row;
    logic [11:0] col;
    logic [23:0] rgb;
  } rd_vec_t;

  rd_vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pat(input logic [11:0] r, input logic [11:0] c);
    return {r[7:0], c[7:0], r[7:0] ^ c[7:0]};
  endfunction

  task automatic drive(input logic [11:0] row, input logic [11:0] col,
                       input logic [11:0] w, input logic [11:0] h,
                       input logic [23:0] rgb, input logic clr);
    WR_VALID  = 1'b1;
    WR_ROW    = row;
    WR_COL    = col;
    WR_WIDTH  = w;
    WR_HEIGHT = h;
    {WR_RED, WR_GREEN, WR_BLUE} = rgb;
    CLEAR     = clr;
  endtask

  task automatic wr(input logic [11:0] row, input logic [11:0] col,
                    input logic [11:0] w, input logic [11:0] h,
                    input logic [23:0] rgb, input logic clr);
    @(negedge CLK);
    drive(row, col, w, h, rgb, clr);
  endtask

  task automatic idle();
    @(negedge CLK);
    WR_VALID = 1'b0;
    CLEAR    = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge CLK);
    WR_VALID = 1'b0;
    CLEAR    = 1'b1;
    @(negedge CLK);
    CLEAR    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] row, input logic [11:0] col,
                    input logic [23:0] exp);
    @(negedge CLK);
    RD_ROW = row;
    RD_COL = col;
    @(negedge CLK);
    check({name, "_valid"}, RD_VALID, 1);
    check({name, "_rgb"}, {RD_RED, RD_GREEN, RD_BLUE}, exp);
  endtask

  task automatic run_reads(input int f);
    for (int i = 0; i < 15; i++)
      if (vecs[i].frame == f)
        rd($sformatf("rd_f%0d_%0d_%0d", f, vecs[i].row, vecs[i].col),
           vecs[i].row, vecs[i].col, vecs[i].rgb);
  endtask

  // Full raster of pat() pixels; checks completion lands on the last write.
  task automatic raster(input string name, input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        @(negedge CLK);
        if (r == h - 1 && c == w - 1)
          check({name, "_notready_before_last"}, FRAME_READY, 0);
        drive(12'(r), 12'(c), 12'(w), 12'(h), pat(12'(r), 12'(c)), 1'b0);
      end
    idle();
    check({name, "_ready"}, FRAME_READY, 1);
    check({name, "_width"}, WIDTH, w);
    check({name, "_height"}, HEIGHT, h);
  endtask

  initial begin
    // frame 0: 32x16 raster
    vecs[0]  = '{0, 12'd5,  12'd20, 24'h051411};
    vecs[1]  = '{0, 12'd15, 12'd31, 24'h0F1F10};
    vecs[2]  = '{0, 12'd0,  12'd0,  24'h000000};
    vecs[3]  = '{0, 12'd10, 12'd3,  24'h0A0309};
    vecs[4]  = '{0, 12'd7,  12'd25, 24'h07191E};
    // frame 1: 4x2 gapped, WR_WIDTH disturbed mid-frame
    vecs[5]  = '{1, 12'd1,  12'd3,  24'h010302};
    vecs[6]  = '{1, 12'd0,  12'd2,  24'h000202};
    vecs[7]  = '{1, 12'd1,  12'd0,  24'h010001};
    // frame 2: 2x2 after CLEAR; (1,0) keeps old data, not the cleared write
    vecs[8]  = '{2, 12'd0,  12'd0,  24'h778899};
    vecs[9]  = '{2, 12'd1,  12'd0,  24'h000202};
    vecs[10] = '{2, 12'd0,  12'd1,  24'h445566};
    vecs[11] = '{2, 12'd1,  12'd1,  24'hAABBCC};
    // frame 3: 16x16 after reset
    vecs[12] = '{3, 12'd15, 12'd15, 24'h0F0F00};
    vecs[13] = '{3, 12'd3,  12'd9,  24'h03090A};
    vecs[14] = '{3, 12'd6,  12'd12, 24'h060C0A};

    RESET = 1'b1; WR_VALID = 1'b0; CLEAR = 1'b0;
    WR_WIDTH = '0; WR_HEIGHT = '0; WR_ROW = '0; WR_COL = '0;
    WR_RED = '0; WR_GREEN = '0; WR_BLUE = '0; RD_ROW = '0; RD_COL = '0;
    #1 RESET = 1'b0;
    #1;
    check("rst_ready", FRAME_READY, 0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_size", {WIDTH, HEIGHT}, 0);
    check("rst_rgb", {RD_RED, RD_GREEN, RD_BLUE}, 0);
    check("rst_err", ERR, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // 1x1 frame goes straight to ready
    wr(0, 0, 1, 1, 24'hAA550F, 1'b0);
    idle();
    check("t6_ready", FRAME_READY, 1);
    check("t6_size", {WIDTH, HEIGHT}, {12'd1, 12'd1});
    rd("t6_rd", 0, 0, 24'hAA550F);
    do_clear();
    check("clr_ready", FRAME_READY, 0);
    check("clr_rd_valid", RD_VALID, 0);
    check("clr_rgb_hold", RD_RED, 8'hAA);

    // raster frame
    raster("t1", 32, 16);
    run_reads(0);

    // 4x2 gapped, width input changed part way through
    do_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 7) check("t2_notready_before_last", FRAME_READY, 0);
      drive(12'(i / 4), 12'(i % 4), (i >= 4) ? 12'd9 : 12'd4, 12'd2,
            pat(12'(i / 4), 12'(i % 4)), 1'b0);
      idle();
    end
    check("t2_ready", FRAME_READY, 1);
    check("t2_size", {WIDTH, HEIGHT}, {12'd4, 12'd2});
    run_reads(1);

    // CLEAR with the third write of a 4x4, then a 2x2 with a repeated pixel
    do_clear();
    wr(0, 0, 4, 4, 24'h010101, 1'b0);
    wr(0, 1, 4, 4, 24'h020202, 1'b0);
    wr(0, 2, 4, 4, 24'hDEADBE, 1'b1);
    wr(0, 0, 2, 2, 24'h112233, 1'b0);
    @(negedge CLK);
    check("t3_new_width", WIDTH, 2);
    drive(0, 1, 2, 2, 24'h445566, 1'b0);
    wr(0, 0, 2, 2, 24'h778899, 1'b0);
    @(negedge CLK);
    check("t3_notready_before_last", FRAME_READY, 0);
    drive(1, 1, 2, 2, 24'hAABBCC, 1'b0);
    idle();
    check("t3_ready", FRAME_READY, 1);
    run_reads(2);

    // asynchronous reset at pixel 100 of 16x16
    do_clear();
    for (int i = 0; i < 100; i++)
      wr(12'(i / 16), 12'(i % 16), 16, 16, pat(12'(i / 16), 12'(i % 16)), 1'b0);
    @(negedge CLK);
    WR_VALID = 1'b0;
    check("t4_width_before", WIDTH, 16);
    #2 RESET = 1'b0;
    #1;
    check("t4_rst_size", {WIDTH, HEIGHT}, 0);
    check("t4_rst_rgb", {RD_RED, RD_GREEN, RD_BLUE}, 0);
    check("t4_rst_flags", {FRAME_READY, RD_VALID, ERR}, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    raster("t4", 16, 16);
    run_reads(3);

`ifdef FB_BOUNDS_CHECK_EN
    // out-of-range write dropped and not counted; out-of-range read is zero
    do_clear();
    for (int i = 0; i < 63; i++)
      wr(12'(i / 8), 12'(i % 8), 8, 8, pat(12'(i / 8), 12'(i % 8)), 1'b0);
    @(negedge CLK);
    check("t5_err_before", ERR, 0);
    drive(9, 0, 8, 8, 24'hFFFFFF, 1'b0);
    @(negedge CLK);
    check("t5_bad_not_counted", FRAME_READY, 0);
    check("t5_err_on_write", ERR, 1);
    drive(7, 7, 8, 8, pat(7, 7), 1'b0);
    idle();
    check("t5_ready", FRAME_READY, 1);
    rd("t5_oob_rd", 0, 8, 24'h000000);
    rd("t5_ok_rd", 2, 3, 24'h020301);
    check("t5_err_sticky", ERR, 1);
    do_clear();
    check("t5_err_cleared", ERR, 0);
`else
    // out-of-frame write still counts and lands at the computed address
    do_clear();
    wr(0, 0, 2, 2, 24'h111111, 1'b0);
    wr(0, 1, 2, 2, 24'h222222, 1'b0);
    wr(3, 0, 2, 2, 24'h123456, 1'b0);
    @(negedge CLK);
    check("wrap_notready_before_last", FRAME_READY, 0);
    drive(1, 0, 2, 2, 24'h333333, 1'b0);
    idle();
    check("wrap_ready", FRAME_READY, 1);
    check("wrap_err_zero", ERR, 0);
    rd("wrap_rd", 3, 0, 24'h123456);
`endif

    // zero-width first write is dropped and leaves the block idle
    do_clear();
    wr(0, 0, 0, 5, 24'h999999, 1'b0);
    wr(0, 0, 1, 1, 24'h0A0B0C, 1'b0);
    idle();
    check("zero_then_1x1_ready", FRAME_READY, 1);
    check("zero_then_1x1_width", WIDTH, 1);
    rd("zero_then_1x1_rd", 0, 0, 24'h0A0B0C);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
